// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-ported word memory between the MIPS32
// instruction-fetch and data ports. It runs one memory transaction at a time,
// registers read data back to the winning port and aborts accesses that the
// memory never answers (optional timeout).
module mips_mem_arbiter #(
    parameter int DATA_BURST_MAX = 4,   // data grants allowed while a fetch waits (>=1)
    parameter int TIMEOUT_CYCLES = 255  // access cycles before abort; 0 disables
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        InstMem_Read,
    input  logic [29:0] InstMem_Address,
    output logic [31:0] InstMem_In,
    output logic        InstMem_Ready,
    input  logic        DataMem_Read,
    input  logic [3:0]  DataMem_Write,
    input  logic [29:0] DataMem_Address,
    input  logic [31:0] DataMem_Out,
    output logic [31:0] DataMem_In,
    output logic        DataMem_Ready,
    output logic [29:0] Mem_Address,
    output logic        Mem_Read,
    output logic [3:0]  Mem_Write,
    output logic [31:0] Mem_WriteData,
    input  logic [31:0] Mem_ReadData,
    input  logic        Mem_Ready,
    output logic        Bus_Error
);

    localparam int BW       = (DATA_BURST_MAX > 0) ? $clog2(DATA_BURST_MAX + 1) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int TW       = (TMO_LAST > 0) ? $clog2(TMO_LAST + 1) : 1;
    localparam bit TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [BW-1:0] BURST_LIMIT = BW'(DATA_BURST_MAX);
    localparam logic [TW-1:0] TMO_LIMIT   = TW'(TMO_LAST);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_INST_ACC = 2'd1,
        S_DATA_ACC = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [BW-1:0]   r_burst_cnt;
    logic [TW-1:0]   r_tmo_cnt;
    logic [31:0]     r_inst_in;
    logic [31:0]     r_data_in;
    logic            r_inst_ready;
    logic            r_data_ready;
    logic            r_bus_error;
    logic [29:0]     r_mem_addr;
    logic            r_mem_read;
    logic [3:0]      r_mem_write;
    logic [31:0]     r_mem_wdata;

    logic w_inst_req;
    logic w_data_req;
    logic w_data_wr;
    logic w_grant_data;
    logic w_grant_inst;
    logic w_in_acc;
    logic w_timeout;
    logic w_acc_done;

    // A write enable on the data port makes the request a write, even if DataMem_Read is also set.
    assign w_inst_req   = InstMem_Read;
    assign w_data_wr    = |DataMem_Write;
    assign w_data_req   = DataMem_Read | w_data_wr;
    // Data has priority until it has been granted DATA_BURST_MAX times in a row over a waiting fetch.
    assign w_grant_data = w_data_req & (~w_inst_req | (r_burst_cnt != BURST_LIMIT));
    assign w_grant_inst = w_inst_req & ~w_grant_data;

    assign w_in_acc   = (r_state == S_INST_ACC) || (r_state == S_DATA_ACC);
    assign w_timeout  = TMO_EN && w_in_acc && !Mem_Ready && (r_tmo_cnt == TMO_LIMIT);
    assign w_acc_done = w_in_acc && (Mem_Ready || w_timeout);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> ACC -> RESP -> IDLE, one transaction at a time.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_data) begin
                    w_state_next = S_DATA_ACC;
                end else if (w_grant_inst) begin
                    w_state_next = S_INST_ACC;
                end
            end
            S_INST_ACC, S_DATA_ACC: begin
                if (w_acc_done) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Burst counter: counts consecutive data grants made while a fetch is waiting.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_burst_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (!w_inst_req || w_grant_inst) begin
                r_burst_cnt <= '0;
            end else if (w_grant_data) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
        end
    end

    // Memory strobes, timeout count, read-data capture and the one-cycle Ready/Bus_Error pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt    <= '0;
            r_inst_in    <= '0;
            r_data_in    <= '0;
            r_inst_ready <= 1'b0;
            r_data_ready <= 1'b0;
            r_bus_error  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_inst_ready <= 1'b0;
            r_data_ready <= 1'b0;
            r_bus_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tmo_cnt <= '0;
                    if (w_grant_data) begin
                        r_mem_addr  <= DataMem_Address;
                        r_mem_read  <= ~w_data_wr;
                        r_mem_write <= DataMem_Write;   // all zero for a read
                        if (w_data_wr) begin
                            r_mem_wdata <= DataMem_Out;
                        end
                    end else if (w_grant_inst) begin
                        r_mem_addr  <= InstMem_Address;
                        r_mem_read  <= 1'b1;
                        r_mem_write <= '0;
                    end
                end
                S_INST_ACC, S_DATA_ACC: begin
                    if (w_acc_done) begin
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= '0;
                        r_inst_ready <= (r_state == S_INST_ACC);
                        r_data_ready <= (r_state == S_DATA_ACC);
                        r_bus_error  <= !Mem_Ready;     // finishing without Mem_Ready means timeout
                        if (r_mem_read) begin
                            if (r_state == S_INST_ACC) begin
                                r_inst_in <= Mem_Ready ? Mem_ReadData : 32'h0;
                            end else begin
                                r_data_in <= Mem_Ready ? Mem_ReadData : 32'h0;
                            end
                        end
                    end else if (TMO_EN) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign InstMem_In    = r_inst_in;
    assign InstMem_Ready = r_inst_ready;
    assign DataMem_In    = r_data_in;
    assign DataMem_Ready = r_data_ready;
    assign Mem_Address   = r_mem_addr;
    assign Mem_Read      = r_mem_read;
    assign Mem_Write     = r_mem_write;
    assign Mem_WriteData = r_mem_wdata;
    assign Bus_Error     = r_bus_error;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: randomized and directed bench for mips_mem_arbiter.
// A behavioural memory answers the main instance; a word-level reference
// memory plus a grant-order rule predicts every Ready, data word and strobe.
module tb_mips_mem_arbiter;

    localparam int BURST = 4;
    localparam int TMO   = 8;

    logic        clock;
    logic        reset_n;

    logic        InstMem_Read;
    logic [29:0] InstMem_Address;
    logic [31:0] InstMem_In;
    logic        InstMem_Ready;
    logic        DataMem_Read;
    logic [3:0]  DataMem_Write;
    logic [29:0] DataMem_Address;
    logic [31:0] DataMem_Out;
    logic [31:0] DataMem_In;
    logic        DataMem_Ready;
    logic [29:0] Mem_Address;
    logic        Mem_Read;
    logic [3:0]  Mem_Write;
    logic [31:0] Mem_WriteData;
    logic [31:0] Mem_ReadData;
    logic        Mem_Ready;
    logic        Bus_Error;

    // second instance, timeout disabled, driven directly by the bench
    logic        InstMem_Read_nt;
    logic [29:0] InstMem_Address_nt;
    logic [31:0] InstMem_In_nt;
    logic        InstMem_Ready_nt;
    logic        DataMem_Read_nt;
    logic [3:0]  DataMem_Write_nt;
    logic [29:0] DataMem_Address_nt;
    logic [31:0] DataMem_Out_nt;
    logic [31:0] DataMem_In_nt;
    logic        DataMem_Ready_nt;
    logic [29:0] Mem_Address_nt;
    logic        Mem_Read_nt;
    logic [3:0]  Mem_Write_nt;
    logic [31:0] Mem_WriteData_nt;
    logic [31:0] Mem_ReadData_nt;
    logic        Mem_Ready_nt;
    logic        Bus_Error_nt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_round  = 0;

    logic [31:0] env_mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] exp_inst;
    logic [31:0] exp_data;
    int          burst_m;

    int          mem_lat;
    bit          mem_silent;
    logic        mem_ready_r;
    logic [31:0] mem_rdata;
    int          mem_cnt;
    logic        stray_ready;

    int          k;
    int          b;
    bit          exp_i;

    assign Mem_Ready    = mem_ready_r | stray_ready;
    assign Mem_ReadData = mem_rdata;

    mips_mem_arbiter #(.DATA_BURST_MAX(BURST), .TIMEOUT_CYCLES(TMO)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .InstMem_Read(InstMem_Read), .InstMem_Address(InstMem_Address),
        .InstMem_In(InstMem_In), .InstMem_Ready(InstMem_Ready),
        .DataMem_Read(DataMem_Read), .DataMem_Write(DataMem_Write),
        .DataMem_Address(DataMem_Address), .DataMem_Out(DataMem_Out),
        .DataMem_In(DataMem_In), .DataMem_Ready(DataMem_Ready),
        .Mem_Address(Mem_Address), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
        .Mem_WriteData(Mem_WriteData), .Mem_ReadData(Mem_ReadData),
        .Mem_Ready(Mem_Ready), .Bus_Error(Bus_Error)
    );

    mips_mem_arbiter #(.DATA_BURST_MAX(BURST), .TIMEOUT_CYCLES(0)) u_dut_nt (
        .clock(clock), .reset_n(reset_n),
        .InstMem_Read(InstMem_Read_nt), .InstMem_Address(InstMem_Address_nt),
        .InstMem_In(InstMem_In_nt), .InstMem_Ready(InstMem_Ready_nt),
        .DataMem_Read(DataMem_Read_nt), .DataMem_Write(DataMem_Write_nt),
        .DataMem_Address(DataMem_Address_nt), .DataMem_Out(DataMem_Out_nt),
        .DataMem_In(DataMem_In_nt), .DataMem_Ready(DataMem_Ready_nt),
        .Mem_Address(Mem_Address_nt), .Mem_Read(Mem_Read_nt), .Mem_Write(Mem_Write_nt),
        .Mem_WriteData(Mem_WriteData_nt), .Mem_ReadData(Mem_ReadData_nt),
        .Mem_Ready(Mem_Ready_nt), .Bus_Error(Bus_Error_nt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] init_word(input int i);
        return {8'hA5, 8'(i), 16'(i * 16'h0101 + 16'h1357)};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory model: answers mem_lat cycles after it first sees a strobe.
    initial begin
        for (int i = 0; i < 256; i++) env_mem[i] = init_word(i);
        mem_ready_r = 1'b0;
        mem_rdata   = 32'h0;
        mem_cnt     = 0;
        forever begin
            @(negedge clock);
            if (!reset_n || mem_ready_r) begin
                mem_ready_r = 1'b0;
                mem_rdata   = $urandom;
                mem_cnt     = 0;
            end else if (Mem_Read || (Mem_Write != 4'b0)) begin
                if (!mem_silent && mem_cnt >= mem_lat) begin
                    mem_ready_r = 1'b1;
                    if (Mem_Read) mem_rdata = env_mem[Mem_Address[7:0]];
                    else env_mem[Mem_Address[7:0]] = merge(env_mem[Mem_Address[7:0]],
                                                           Mem_WriteData, Mem_Write);
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // One round: present an inst and/or data request together and check every cycle until done.
    task automatic run_round(input int kind, input int lat, input logic [29:0] ia,
                             input logic [29:0] da, input logic [3:0] be,
                             input logic [31:0] wd, input bit drd);
        bit          has_i, has_d, is_wr, inst_first, acc_inst;
        int          t_first, t_second, t_i, t_d, t_last;
        logic [31:0] e_inst, e_data;
        has_i      = (kind != 2);
        has_d      = (kind != 1);
        is_wr      = (be != 4'b0);
        inst_first = has_i && (!has_d || burst_m == BURST);
        if (inst_first || !has_i) burst_m = 0;
        else burst_m++;
        if (has_i && has_d) burst_m = 0;

        e_inst = exp_inst;
        e_data = exp_data;
        if (has_i && inst_first) e_inst = ref_mem[ia[7:0]];
        if (has_d) begin
            if (is_wr) ref_mem[da[7:0]] = merge(ref_mem[da[7:0]], wd, be);
            else e_data = ref_mem[da[7:0]];
        end
        if (has_i && !inst_first) e_inst = ref_mem[ia[7:0]];

        t_first  = lat + 2;
        t_second = 2 * lat + 5;
        t_i      = !has_i ? -1 : (inst_first ? t_first : t_second);
        t_d      = !has_d ? -1 : (inst_first ? t_second : t_first);
        t_last   = (has_i && has_d) ? t_second + 1 : t_first + 1;

        n_round++;
        $display("round %0d: kind=%0d lat=%0d ia=%h da=%h be=%h wd=%h inst_first=%0d",
                 n_round, kind, lat, ia, da, be, wd, inst_first);
        mem_lat         = lat;
        InstMem_Read    = has_i;
        InstMem_Address = ia;
        DataMem_Read    = has_d && (is_wr ? drd : 1'b1);
        DataMem_Write   = has_d ? be : 4'b0;
        DataMem_Address = da;
        DataMem_Out     = wd;
        for (int n = 1; n <= t_last; n++) begin
            @(negedge clock);
            if (n == 1 || (has_i && has_d && n == t_first + 2)) begin
                acc_inst = (n == 1) ? inst_first : !inst_first;
                if (acc_inst) begin
                    check_eq("strobe_rd_inst", 32'(Mem_Read), 32'd1);
                    check_eq("strobe_wr_inst", 32'(Mem_Write), 32'd0);
                    check_eq("addr_inst", 32'(Mem_Address), 32'(ia));
                end else begin
                    check_eq("strobe_rd_data", 32'(Mem_Read), 32'(!is_wr));
                    check_eq("strobe_wr_data", 32'(Mem_Write), 32'(be));
                    check_eq("addr_data", 32'(Mem_Address), 32'(da));
                    if (is_wr) check_eq("wdata", Mem_WriteData, wd);
                end
            end
            check_eq("inst_ready", 32'(InstMem_Ready), 32'(n == t_i));
            check_eq("data_ready", 32'(DataMem_Ready), 32'(n == t_d));
            check_eq("bus_error", 32'(Bus_Error), 32'd0);
            if (n == t_i) begin
                check_eq("inst_in", InstMem_In, e_inst);
                InstMem_Read = 1'b0;
            end
            if (n == t_d) begin
                check_eq("data_in", DataMem_In, e_data);
                DataMem_Read  = 1'b0;
                DataMem_Write = 4'b0;
            end
        end
        exp_inst = e_inst;
        exp_data = e_data;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        reset_n = 1'b0;
        mem_lat = 1; mem_silent = 1'b0; stray_ready = 1'b0;
        InstMem_Read = 1'b0; InstMem_Address = '0;
        DataMem_Read = 1'b0; DataMem_Write = '0; DataMem_Address = '0; DataMem_Out = '0;
        InstMem_Read_nt = 1'b0; InstMem_Address_nt = '0;
        DataMem_Read_nt = 1'b0; DataMem_Write_nt = '0; DataMem_Address_nt = '0;
        DataMem_Out_nt = '0; Mem_ReadData_nt = '0; Mem_Ready_nt = 1'b0;
        exp_inst = '0; exp_data = '0; burst_m = 0;

        // power-on reset
        repeat (3) @(negedge clock);
        check_eq("por_inst_in", InstMem_In, 32'h0);
        check_eq("por_data_in", DataMem_In, 32'h0);
        check_eq("por_ctl", 32'({InstMem_Ready, DataMem_Ready, Mem_Read, Mem_Write, Bus_Error}), 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        // instruction fetch of a known word, then a byte write that also raises DataMem_Read
        run_round(2, 1, 30'h0, 30'h40, 4'hF, 32'h8C010004, 1'b0);
        run_round(1, 1, 30'h40, 30'h0, 4'h0, 32'h0, 1'b0);
        run_round(2, 1, 30'h0, 30'h21, 4'b0010, 32'h0000AB00, 1'b1);

        // randomized mix
        for (int r = 0; r < 40; r++) begin
            run_round($urandom_range(1, 3), $urandom_range(1, 3),
                      30'($urandom_range(0, 15)), 30'($urandom_range(0, 15)),
                      ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                      $urandom, ($urandom_range(0, 1) == 1));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        // continuous contention: inst is granted after every BURST data grants
        mem_lat = 1;
        InstMem_Read = 1'b1; InstMem_Address = 30'h44;
        DataMem_Read = 1'b1; DataMem_Write = 4'b0; DataMem_Address = 30'h45;
        b = burst_m;
        k = 0;
        for (int n = 0; n < 200 && k < 10; n++) begin
            @(negedge clock);
            check_eq("one_ready", 32'(InstMem_Ready & DataMem_Ready), 32'd0);
            if (InstMem_Ready || DataMem_Ready) begin
                exp_i = (b == BURST);
                if (exp_i) b = 0;
                else b++;
                $display("contention grant %0d: %s", k, InstMem_Ready ? "I" : "D");
                check_eq("grant_order", 32'(InstMem_Ready), 32'(exp_i));
                if (InstMem_Ready) check_eq("cont_inst_in", InstMem_In, ref_mem[8'h44]);
                else check_eq("cont_data_in", DataMem_In, ref_mem[8'h45]);
                k++;
            end
        end
        check_eq("grant_count", 32'(k), 32'd10);
        InstMem_Read = 1'b0; DataMem_Read = 1'b0;
        burst_m = 0; exp_inst = ref_mem[8'h44]; exp_data = ref_mem[8'h45];
        repeat (2) @(negedge clock);

        // timeout on a silent data read
        run_round(2, 2, 30'h0, 30'h3, 4'h0, 32'h0, 1'b1);
        mem_silent = 1'b1;
        DataMem_Read = 1'b1; DataMem_Address = 30'h7;
        $display("timeout read at 0x7");
        for (int n = 1; n <= TMO + 2; n++) begin
            @(negedge clock);
            check_eq("tmo_ready", 32'(DataMem_Ready), 32'(n == TMO + 1));
            check_eq("tmo_error", 32'(Bus_Error), 32'(n == TMO + 1));
            check_eq("tmo_strobe", 32'(Mem_Read), 32'(n <= TMO));
            if (n == TMO + 1) begin
                check_eq("tmo_data_in", DataMem_In, 32'h0);
                DataMem_Read = 1'b0;
            end
        end
        mem_silent = 1'b0;
        exp_data = 32'h0;
        run_round(2, 1, 30'h0, 30'h5, 4'h0, 32'h0, 1'b1);

        // slow memory on the instance without timeout
        DataMem_Read_nt = 1'b1; DataMem_Address_nt = 30'h15;
        $display("slow read at 0x15 (20-cycle memory)");
        for (int n = 1; n <= 22; n++) begin
            @(negedge clock);
            if (n <= 20) begin
                check_eq("slow_rd", 32'(Mem_Read_nt), 32'd1);
                check_eq("slow_wr", 32'(Mem_Write_nt), 32'd0);
                check_eq("slow_addr", 32'(Mem_Address_nt), 32'h15);
            end
            check_eq("slow_ready", 32'(DataMem_Ready_nt), 32'(n == 21));
            check_eq("slow_error", 32'(Bus_Error_nt), 32'd0);
            if (n == 20) begin
                Mem_Ready_nt = 1'b1; Mem_ReadData_nt = 32'hCAFE0015;
            end
            if (n == 21) begin
                Mem_Ready_nt = 1'b0; Mem_ReadData_nt = 32'h0;
                check_eq("slow_data_in", DataMem_In_nt, 32'hCAFE0015);
                DataMem_Read_nt = 1'b0;
            end
        end

        // reset in the middle of a data access, then a stray Mem_Ready
        mem_silent = 1'b1;
        DataMem_Read = 1'b1; DataMem_Address = 30'h9;
        $display("reset during data access");
        repeat (3) @(negedge clock);
        check_eq("pre_rst_strobe", 32'(Mem_Read), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_inst_in", InstMem_In, 32'h0);
        check_eq("rst_data_in", DataMem_In, 32'h0);
        check_eq("rst_addr", 32'(Mem_Address), 32'h0);
        check_eq("rst_wdata", Mem_WriteData, 32'h0);
        check_eq("rst_ctl", 32'({InstMem_Ready, DataMem_Ready, Mem_Read, Mem_Write, Bus_Error}), 32'h0);
        repeat (3) @(negedge clock);
        DataMem_Read = 1'b0;
        reset_n = 1'b1;
        mem_silent = 1'b0;
        @(negedge clock);
        stray_ready = 1'b1;
        @(negedge clock);
        stray_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clock);
            check_eq("stray_ready", 32'({InstMem_Ready, DataMem_Ready, Bus_Error, Mem_Read}), 32'h0);
        end
        exp_inst = 32'h0; exp_data = 32'h0; burst_m = 0;
        run_round(3, 1, 30'h2, 30'h3, 4'h0, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
